// File: rtl/oam_dma.sv
// Sprite DMA bridge between the CPU port and the system bus: passes CPU cycles through
// while idle, and on a write to the DMA register stalls the CPU and copies one page to OAM.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_we,
  input  logic [7:0]  bus_d_in,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  idx_r;
  logic [7:0]  page_r;
  logic [7:0]  buf_r;
  logic        par_r;
  logic        trigger_s;

  function automatic logic is_dma_trigger(input logic we, input logic [15:0] addr);
    return we && (addr == DMA_REG_ADDR);
  endfunction

  assign trigger_s = is_dma_trigger(cpu_we, cpu_addr);

  // State, page/index/buffer registers and the free-running cycle parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 8'h00;
      page_r  <= 8'h00;
      buf_r   <= 8'h00;
      par_r   <= 1'b0;
    end else begin
      par_r   <= ~par_r;
      state_r <= next_state_s;
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            page_r <= cpu_d_out;
            idx_r  <= 8'h00;
          end
        end
        ST_READ:  buf_r <= bus_d_in;
        ST_WRITE: idx_r <= idx_r + 8'h01;
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Next-state selection; HALT detours through ALIGN so every READ lands on even parity.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) next_state_s = ST_HALT;
        else           next_state_s = ST_IDLE;
      end
      ST_HALT: begin
        if (par_r) next_state_s = ST_READ;
        else       next_state_s = ST_ALIGN;
      end
      ST_ALIGN: next_state_s = ST_READ;
      ST_READ:  next_state_s = ST_WRITE;
      ST_WRITE: begin
        if (idx_r == 8'hFF) next_state_s = ST_IDLE;
        else                next_state_s = ST_READ;
      end
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Bus and handshake outputs; idle defaults mirror the CPU port.
  always_comb begin
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    bus_addr   = cpu_addr;
    bus_d_out  = cpu_d_out;
    bus_we     = cpu_we;
    case (state_r)
      ST_IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
      end
      ST_HALT, ST_ALIGN: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_we     = 1'b0;
      end
      ST_READ: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = {page_r, idx_r};
        bus_d_out  = buf_r;
        bus_we     = 1'b0;
      end
      ST_WRITE: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = OAM_DATA_ADDR;
        bus_d_out  = buf_r;
        bus_we     = 1'b1;
      end
      default: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes every expected bus write, a monitor
// pops and compares each observed bus write, and DMA stall lengths are counted.
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  logic [15:0] last_rd_addr = 16'h0000;
  logic [7:0]  last_wr_data = 8'h00;
  logic [31:0] cyc;
  logic [23:0] sb_q[$];

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_d_out  (cpu_d_out),
    .cpu_we     (cpu_we),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_d_out  (bus_d_out),
    .bus_we     (bus_we),
    .bus_d_in   (bus_d_in),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: page FF holds its own low byte, other pages are low byte xor page.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    if (a[15:8] == 8'hFF) return a[7:0];
    return a[7:0] ^ a[15:8];
  endfunction

  assign bus_d_in = mem_f(bus_addr);

  // Cycle count since reset release; its LSB equals the DUT's parity flop.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 32'd0;
    else      cyc <= cyc + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every bus write and counts stalled cycles.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (!cpu_rdy) stall_cnt++;
      if (dma_active && !bus_we) last_rd_addr = bus_addr;
      if (bus_we) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_bus_write", {8'h00, bus_addr, bus_d_out}, 32'hFFFFFFFF);
        end else begin
          chk("bus_write", {8'h00, bus_addr, bus_d_out}, {8'h00, sb_q.pop_front()});
        end
        last_wr_data = bus_d_out;
      end
    end
  end

  task automatic align_par(input logic p);
    while (cyc[0] != p) @(negedge clk);
  endtask

  // Called at a negedge while idle: triggers a DMA of the given page and waits it out.
  task automatic run_dma(input logic [7:0] page, input logic hammer);
    logic par_at_trig;
    int   n;
    par_at_trig = cyc[0];
    cpu_addr  = 16'h4014;
    cpu_d_out = page;
    cpu_we    = 1'b1;
    sb_q.push_back({16'h4014, page});
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = i[7:0];
      sb_q.push_back({16'h2004, mem_f({page, lo})});
    end
    stall_cnt = 0;
    n = 0;
    @(negedge clk);
    while (dma_active && n < 600) begin
      if (hammer) begin
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h77;
        cpu_we    = 1'b1;
      end else begin
        cpu_addr  = 16'h0000;
        cpu_we    = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    chk("dma_finished_in_budget", {31'd0, n < 600}, 32'd1);
    chk("stall_cycles", stall_cnt, par_at_trig ? 32'd514 : 32'd513);
    chk("rdy_after_dma", {31'd0, cpu_rdy}, 32'd1);
    chk("active_after_dma", {31'd0, dma_active}, 32'd0);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    int wcnt;
    rst       = 1'b0;
    cpu_addr  = 16'hBEEF;
    cpu_d_out = 8'h00;
    cpu_we    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("reset_active", {31'd0, dma_active}, 32'd0);
    chk("reset_bus_addr", {16'd0, bus_addr}, 32'h0000BEEF);
    chk("reset_bus_we", {31'd0, bus_we}, 32'd0);
    rst = 1'b1;

    @(negedge clk);
    cpu_addr  = 16'h0300;
    cpu_d_out = 8'h5A;
    cpu_we    = 1'b1;
    sb_q.push_back({16'h0300, 8'h5A});
    #1;
    chk("pass_addr", {16'd0, bus_addr}, 32'h00000300);
    chk("pass_data", {24'd0, bus_d_out}, 32'h0000005A);
    chk("pass_we", {31'd0, bus_we}, 32'd1);
    chk("pass_rdy", {31'd0, cpu_rdy}, 32'd1);
    @(negedge clk);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;

    // Even-parity trigger, CPU hammering the DMA register throughout.
    @(negedge clk);
    align_par(1'b0);
    run_dma(8'h02, 1'b1);

    // Odd-parity trigger on the top page, then an immediate back-to-back trigger.
    @(negedge clk);
    align_par(1'b1);
    run_dma(8'hFF, 1'b0);
    chk("ff_last_read", {16'd0, last_rd_addr}, 32'h0000FFFF);
    chk("ff_last_write_data", {24'd0, last_wr_data}, 32'h000000FF);
    run_dma(8'h03, 1'b0);

    // Reset abort after 100 DMA writes.
    @(negedge clk);
    cpu_addr  = 16'h4014;
    cpu_d_out = 8'h04;
    cpu_we    = 1'b1;
    sb_q.push_back({16'h4014, 8'h04});
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = i[7:0];
      sb_q.push_back({16'h2004, mem_f({8'h04, lo})});
    end
    wcnt = 0;
    for (int k = 0; k < 400 && wcnt < 100; k++) begin
      @(negedge clk);
      cpu_we   = 1'b0;
      cpu_addr = 16'h1234;
      if (dma_active && bus_we) wcnt++;
    end
    chk("abort_write_count", wcnt, 32'd100);
    #3;
    sb_q.delete();
    rst = 1'b0;
    #1;
    chk("abort_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("abort_active", {31'd0, dma_active}, 32'd0);
    chk("abort_bus_addr", {16'd0, bus_addr}, 32'h00001234);
    chk("abort_bus_we", {31'd0, bus_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cpu_addr  = 16'h0155;
    cpu_d_out = 8'hA3;
    cpu_we    = 1'b1;
    sb_q.push_back({16'h0155, 8'hA3});
    #1;
    chk("post_abort_addr", {16'd0, bus_addr}, 32'h00000155);
    chk("post_abort_data", {24'd0, bus_d_out}, 32'h000000A3);
    chk("post_abort_we", {31'd0, bus_we}, 32'd1);
    @(negedge clk);
    cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", sb_q.size(), 32'd0);
    chk("final_idle", {31'd0, dma_active}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
